// File: rtl/rns_alu_scheduler_pkg.sv
// Shared types and widths for the RNS ALU scheduler: opcodes, FSM states,
// datapath widths and the modulus legality check.
package rns_alu_scheduler_pkg;

   localparam int MOD_W  = 3;
   localparam int OPND_W = 4;
   localparam int RES_W  = 7;

   typedef enum logic [1:0] {
      OP_SUM  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_ZERO = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } sched_state_e;

   // A modulus below 2 makes the residue channel meaningless.
   function automatic logic modulus_legal(input logic [MOD_W-1:0] m);
      return m >= MOD_W'(2);
   endfunction

endpackage

// File: rtl/rns_alu_scheduler_arb.sv
// Two-way round-robin arbiter. On a tie the requester that did not win
// last time is granted; a single valid requester always wins. The grant is
// one-hot or zero, and zero whenever enable is low.
module rr_arbiter_2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   // Purely combinational grant selection.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/rns_alu_scheduler.sv
// Sequencer for the shared combinational RNS ALU. Grants one of two
// requesters, holds operands and moduli on the ALU inputs for SETTLE_CYCLES,
// captures the result and returns it on a response channel tagged with the
// requester id. Also owns the moduli configuration registers.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. reqN_ready is combinational and is only raised in IDLE, only to the
// granted requester and never while cfg_we is high; a requester must hold its
// operands stable while valid is high and ready is low. rsp_valid stays high,
// with rsp_id/rsp_result stable, until the edge where rsp_ready is also 1.
module rns_alu_scheduler
   import rns_alu_scheduler_pkg::*;
#(
   parameter int               SETTLE_CYCLES = 2,
   parameter logic [MOD_W-1:0] RST_M1        = 3'd3,
   parameter logic [MOD_W-1:0] RST_M2        = 3'd5,
   parameter logic [MOD_W-1:0] RST_M3        = 3'd7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [MOD_W-1:0]  cfg_m1,
   input  logic [MOD_W-1:0]  cfg_m2,
   input  logic [MOD_W-1:0]  cfg_m3,
   output logic              cfg_err,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPND_W-1:0] req0_a,
   input  logic [OPND_W-1:0] req0_b,
   input  logic [1:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPND_W-1:0] req1_a,
   input  logic [OPND_W-1:0] req1_b,
   input  logic [1:0]        req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [RES_W-1:0]  rsp_result,
   output logic [OPND_W-1:0] alu_a,
   output logic [OPND_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   output logic [MOD_W-1:0]  alu_m1,
   output logic [MOD_W-1:0]  alu_m2,
   output logic [MOD_W-1:0]  alu_m3,
   input  logic [RES_W-1:0]  alu_result,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;
   logic             last_grant_q;
   logic [1:0]       grant;
   logic             accept;
   logic             in_idle;
   logic             cfg_ok;

   assign in_idle   = (state_q == ST_IDLE);
   assign cfg_ok    = cfg_we && in_idle && modulus_legal(cfg_m1) &&
                      modulus_legal(cfg_m2) && modulus_legal(cfg_m3);
   assign accept    = |grant;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = !in_idle;
   assign dbg_state = state_q;

   // A config write in IDLE takes the cycle, so requests wait one cycle and
   // the next operation sees the new moduli.
   rr_arbiter_2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .enable     (in_idle && !cfg_we),
      .grant      (grant)
   );

   // FSM state and settle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: the counter is loaded on accept and the result is
   // captured on the edge where it reaches one, i.e. SETTLE_CYCLES edges later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
               cnt_d   = CNT_W'(SETTLE_CYCLES);
            end
         end
         ST_EXEC: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, moduli registers, response capture, error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= OP_ZERO;
         alu_m1       <= RST_M1;
         alu_m2       <= RST_M2;
         alu_m3       <= RST_M3;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         last_grant_q <= 1'b1;
         cfg_err      <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_ok) begin
            alu_m1 <= cfg_m1;
            alu_m2 <= cfg_m2;
            alu_m3 <= cfg_m3;
         end
         if (accept) begin
            alu_a        <= grant[1] ? req1_a  : req0_a;
            alu_b        <= grant[1] ? req1_b  : req0_b;
            alu_op       <= grant[1] ? req1_op : req0_op;
            rsp_id       <= grant[1];
            last_grant_q <= grant[1];
         end
         if (capture) rsp_result <= alu_result;
      end
   end

endmodule
